// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single 256x8 data-memory port between
// the core (A) and the init/dump loader (B), one access per grant.
module dmem_arbiter #(
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int LOCK_MAX = 16
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_ack,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_ack,
    output logic [DW-1:0] b_rdata,
    input  logic          b_lock,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,
    output logic          owner
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic [7:0] LockMax = 8'(LOCK_MAX);

    state_e        state_q, state_d;
    logic          cmd_we_q, cmd_we_d;
    logic [AW-1:0] cmd_addr_q, cmd_addr_d;
    logic [DW-1:0] cmd_wdata_q, cmd_wdata_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic [7:0]    lock_q, lock_d;
    logic [DW-1:0] a_rdata_q, a_rdata_d;
    logic [DW-1:0] b_rdata_q, b_rdata_d;

    logic in_resp;
    logic a_v, b_v;
    logic lock_win;
    logic grant, win_b;

    // Arbitration: mask the owner's own held request in RESP, round-robin
    // on contention, and let a locked B keep the port up to LOCK_MAX times.
    always_comb begin
        in_resp  = (state_q == RESP);
        a_v      = a_req & ~(in_resp & ~owner_q);
        b_v      = b_req & ~(in_resp & owner_q);
        lock_win = last_q & b_lock & b_req & (lock_q < LockMax);
        grant    = 1'b0;
        win_b    = 1'b0;
        if (lock_win) begin
            grant = 1'b1;
            win_b = 1'b1;
        end else if (a_v && b_v) begin
            grant = 1'b1;
            win_b = ~last_q;
        end else if (a_v) begin
            grant = 1'b1;
            win_b = 1'b0;
        end else if (b_v) begin
            grant = 1'b1;
            win_b = 1'b1;
        end
    end

    // Next-state and register updates for the IDLE/ACCESS/RESP sequencer.
    always_comb begin
        state_d     = state_q;
        cmd_we_d    = cmd_we_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        owner_d     = owner_q;
        last_d      = last_q;
        lock_d      = lock_q;
        a_rdata_d   = a_rdata_q;
        b_rdata_d   = b_rdata_q;
        unique case (state_q)
            IDLE, RESP: begin
                if (grant) begin
                    state_d     = ACCESS;
                    owner_d     = win_b;
                    last_d      = win_b;
                    cmd_we_d    = win_b ? b_we    : a_we;
                    cmd_addr_d  = win_b ? b_addr  : a_addr;
                    cmd_wdata_d = win_b ? b_wdata : a_wdata;
                end else begin
                    state_d = IDLE;
                end
                if (grant && !win_b) begin
                    lock_d = 8'd0;
                end else if (!b_lock) begin
                    lock_d = 8'd0;
                end else if (grant && win_b && (lock_q < LockMax)) begin
                    lock_d = lock_q + 8'd1;
                end
            end
            ACCESS: begin
                state_d = RESP;
                if (!cmd_we_q) begin
                    if (owner_q) b_rdata_d = mem_rdata;
                    else         a_rdata_d = mem_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset; last owner starts as B so
    // that A wins the first contended arbitration.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            lock_q      <= 8'd0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            cmd_we_q    <= cmd_we_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            lock_q      <= lock_d;
            a_rdata_q   <= a_rdata_d;
            b_rdata_q   <= b_rdata_d;
        end
    end

    // The write strobe is gated by RESET so a reset landing in ACCESS
    // never commits the pending write.
    assign mem_we    = (state_q == ACCESS) & cmd_we_q & ~RESET;
    assign mem_addr  = cmd_addr_q;
    assign mem_wdata = cmd_wdata_q;
    assign a_ack     = (state_q == RESP) & ~owner_q;
    assign b_ack     = (state_q == RESP) & owner_q;
    assign a_rdata   = a_rdata_q;
    assign b_rdata   = b_rdata_q;
    assign owner     = owner_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios for dmem_arbiter with a
// behavioural 256x8 memory (sync write, combinational read).
module tb_dmem_arbiter;

    logic       CLK;
    logic       RESET;
    logic       a_req, a_we, a_ack;
    logic [7:0] a_addr, a_wdata, a_rdata;
    logic       b_req, b_we, b_ack, b_lock;
    logic [7:0] b_addr, b_wdata, b_rdata;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       mem_we, owner;

    logic [7:0] mem [256];

    int tests;
    int fails;

    dmem_arbiter #(.AW(8), .DW(8), .LOCK_MAX(16)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .a_req     (a_req),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_ack     (a_ack),
        .a_rdata   (a_rdata),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_ack     (b_ack),
        .b_rdata   (b_rdata),
        .b_lock    (b_lock),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .owner     (owner)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) if (mem_we) mem[mem_addr] <= mem_wdata;
    assign mem_rdata = mem[mem_addr];

    task automatic test_reset();
        RESET = 1'b1;
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0; b_lock = 0;
        repeat (2) @(negedge CLK);
        tests++;
        if ({a_ack, b_ack, mem_we, owner} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_ctl: got %b want 0000",
                     {a_ack, b_ack, mem_we, owner});
        end
        tests++;
        if ({a_rdata, b_rdata} !== 16'h0000) begin
            fails++;
            $display("FAIL reset_rdata: got %h want 0000", {a_rdata, b_rdata});
        end
        tests++;
        if ({mem_addr, mem_wdata} !== 16'h0000) begin
            fails++;
            $display("FAIL reset_cmd: got %h want 0000", {mem_addr, mem_wdata});
        end
        RESET = 1'b0;
    endtask

    task automatic test_a_write_read();
        a_req = 1; a_we = 1; a_addr = 8'h10; a_wdata = 8'h5A;
        @(negedge CLK);
        tests++;
        if ({mem_we, mem_addr, mem_wdata, a_ack} !== {1'b1, 8'h10, 8'h5A, 1'b0}) begin
            fails++;
            $display("FAIL a_wr_access: got we=%b addr=%h wd=%h ack=%b want 1 10 5a 0",
                     mem_we, mem_addr, mem_wdata, a_ack);
        end
        @(negedge CLK);
        tests++;
        if ({a_ack, b_ack, mem_we} !== 3'b100) begin
            fails++;
            $display("FAIL a_wr_ack: got %b want 100", {a_ack, b_ack, mem_we});
        end
        a_we = 0; a_wdata = 0;
        @(negedge CLK);
        tests++;
        if (a_ack !== 1'b0) begin
            fails++;
            $display("FAIL a_masked: got ack=%b want 0", a_ack);
        end
        @(negedge CLK);
        tests++;
        if ({mem_we, mem_addr} !== {1'b0, 8'h10}) begin
            fails++;
            $display("FAIL a_rd_access: got we=%b addr=%h want 0 10", mem_we, mem_addr);
        end
        @(negedge CLK);
        tests++;
        if ({a_ack, a_rdata} !== {1'b1, 8'h5A}) begin
            fails++;
            $display("FAIL a_rd_ack: got ack=%b rd=%h want 1 5a", a_ack, a_rdata);
        end
        a_req = 0;
    endtask

    task automatic test_both_from_idle();
        RESET = 1;
        @(negedge CLK);
        RESET = 0;
        a_req = 1; a_we = 0; a_addr = 8'h01;
        b_req = 1; b_we = 1; b_addr = 8'h02; b_wdata = 8'h33;
        @(negedge CLK);
        tests++;
        if ({owner, mem_we, mem_addr} !== {1'b0, 1'b0, 8'h01}) begin
            fails++;
            $display("FAIL both_first: got own=%b we=%b addr=%h want 0 0 01",
                     owner, mem_we, mem_addr);
        end
        @(negedge CLK);
        tests++;
        if ({a_ack, b_ack, a_rdata} !== {1'b1, 1'b0, 8'h00}) begin
            fails++;
            $display("FAIL both_a_ack: got a=%b b=%b rd=%h want 1 0 00",
                     a_ack, b_ack, a_rdata);
        end
        a_req = 0;
        @(negedge CLK);
        tests++;
        if ({owner, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 8'h02, 8'h33}) begin
            fails++;
            $display("FAIL both_second: got own=%b we=%b addr=%h wd=%h want 1 1 02 33",
                     owner, mem_we, mem_addr, mem_wdata);
        end
        @(negedge CLK);
        tests++;
        if ({a_ack, b_ack} !== 2'b01) begin
            fails++;
            $display("FAIL both_b_ack: got %b want 01", {a_ack, b_ack});
        end
        b_req = 0;
    endtask

    task automatic test_alternate();
        int order[$];
        int last_a, last_b;
        last_a = 0; last_b = 0;
        b_lock = 0;
        @(negedge CLK);
        a_req = 1; a_we = 0; a_addr = 8'h00;
        b_req = 1; b_we = 0; b_addr = 8'h80;
        for (int k = 1; k <= 20; k++) begin
            @(negedge CLK);
            if (a_ack && b_ack) begin
                tests++; fails++;
                $display("FAIL alt_double_ack: cycle %0d both acks high", k);
            end
            if (a_ack) begin
                order.push_back(0);
                tests++;
                if (k - last_a > 4) begin
                    fails++;
                    $display("FAIL alt_a_wait: got gap %0d want <=4", k - last_a);
                end
                last_a = k;
                a_addr = a_addr + 8'd1;
            end
            if (b_ack) begin
                order.push_back(1);
                tests++;
                if (k - last_b > 4) begin
                    fails++;
                    $display("FAIL alt_b_wait: got gap %0d want <=4", k - last_b);
                end
                last_b = k;
                b_addr = b_addr + 8'd1;
            end
        end
        a_req = 0; b_req = 0;
        tests++;
        if (order.size() != 10) begin
            fails++;
            $display("FAIL alt_count: got %0d acks want 10", order.size());
        end
        for (int i = 0; i < order.size(); i++) begin
            tests++;
            if (order[i] != (i % 2)) begin
                fails++;
                $display("FAIL alt_order[%0d]: got %0d want %0d", i, order[i], i % 2);
            end
        end
    endtask

    task automatic test_lock_burst();
        int seq[$];
        int bsent;
        bit adone;
        bsent = 0; adone = 0;
        b_lock = 1;
        a_req = 1; a_we = 0; a_addr = 8'h50;
        b_req = 1; b_we = 1; b_addr = 8'h40; b_wdata = 8'h80;
        for (int k = 0; k < 150 && !(bsent == 20 && adone); k++) begin
            @(negedge CLK);
            if (b_ack) begin
                seq.push_back(1);
                bsent++;
                if (bsent == 20) begin
                    b_req = 0;
                end else begin
                    b_addr  = 8'h40 + 8'(bsent);
                    b_wdata = 8'h80 + 8'(bsent);
                end
            end
            if (a_ack) begin
                seq.push_back(0);
                adone = 1;
                a_req = 0;
            end
        end
        b_req = 0; a_req = 0; b_lock = 0;
        tests++;
        if (seq.size() != 21) begin
            fails++;
            $display("FAIL lock_count: got %0d acks want 21", seq.size());
        end
        for (int i = 0; i < seq.size(); i++) begin
            tests++;
            if (seq[i] != ((i == 16) ? 0 : 1)) begin
                fails++;
                $display("FAIL lock_seq[%0d]: got %0d want %0d",
                         i, seq[i], (i == 16) ? 0 : 1);
            end
        end
        tests++;
        if (mem[8'h53] !== 8'h93) begin
            fails++;
            $display("FAIL lock_last_write: got %h want 93", mem[8'h53]);
        end
    endtask

    task automatic test_reset_in_access();
        @(negedge CLK);
        b_req = 1; b_we = 1; b_addr = 8'h20; b_wdata = 8'h77;
        @(negedge CLK);
        tests++;
        if ({mem_we, mem_addr} !== {1'b1, 8'h20}) begin
            fails++;
            $display("FAIL rst_acc_pre: got we=%b addr=%h want 1 20", mem_we, mem_addr);
        end
        RESET = 1; b_req = 0;
        #1;
        tests++;
        if (mem_we !== 1'b0) begin
            fails++;
            $display("FAIL rst_acc_we: got %b want 0", mem_we);
        end
        @(negedge CLK);
        tests++;
        if ({a_ack, b_ack, mem_we, owner, mem_addr, mem_wdata, a_rdata, b_rdata}
            !== 36'h0) begin
            fails++;
            $display("FAIL rst_acc_outs: got %h want 0",
                     {a_ack, b_ack, mem_we, owner, mem_addr, mem_wdata, a_rdata, b_rdata});
        end
        RESET = 0;
        a_req = 1; a_we = 0; a_addr = 8'h20;
        repeat (2) @(negedge CLK);
        tests++;
        if ({a_ack, a_rdata} !== {1'b1, 8'h00}) begin
            fails++;
            $display("FAIL rst_acc_readback: got ack=%b rd=%h want 1 00", a_ack, a_rdata);
        end
        a_req = 0;
    endtask

    task automatic test_addr_ff();
        b_req = 1; b_we = 1; b_addr = 8'hFF; b_wdata = 8'hFF;
        @(negedge CLK);
        tests++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 8'hFF, 8'hFF}) begin
            fails++;
            $display("FAIL ff_write: got we=%b addr=%h wd=%h want 1 ff ff",
                     mem_we, mem_addr, mem_wdata);
        end
        @(negedge CLK);
        tests++;
        if (b_ack !== 1'b1) begin
            fails++;
            $display("FAIL ff_wr_ack: got %b want 1", b_ack);
        end
        b_we = 0; b_wdata = 0;
        repeat (2) @(negedge CLK);
        tests++;
        if ({mem_we, mem_addr} !== {1'b0, 8'hFF}) begin
            fails++;
            $display("FAIL ff_read: got we=%b addr=%h want 0 ff", mem_we, mem_addr);
        end
        @(negedge CLK);
        tests++;
        if ({b_ack, b_rdata} !== {1'b1, 8'hFF}) begin
            fails++;
            $display("FAIL ff_rd_ack: got ack=%b rd=%h want 1 ff", b_ack, b_rdata);
        end
        RESET = 1; b_req = 0;
        #1;
        tests++;
        if (b_ack !== 1'b1) begin
            fails++;
            $display("FAIL rst_resp_ack: got %b want 1", b_ack);
        end
        @(negedge CLK);
        tests++;
        if ({b_ack, b_rdata} !== {1'b0, 8'h00}) begin
            fails++;
            $display("FAIL rst_resp_after: got ack=%b rd=%h want 0 00", b_ack, b_rdata);
        end
        RESET = 0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        test_reset();
        test_a_write_read();
        test_both_from_idle();
        test_alternate();
        test_lock_burst();
        test_reset_in_access();
        test_addr_ff();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
